// File: rtl/fpga_robots_game_tmarb.sv
// Two-port arbiter for the shared tile-map memory: game play (A) and host debug (B).
// A normally wins contention; B is forced through after STARVE consecutive losses.
module fpga_robots_game_tmarb #(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned STARVE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic [12:0] a_adr,
   input  logic [7:0]  a_wrt,
   input  logic        a_wen,
   output logic        a_gnt,
   output logic [7:0]  a_red,
   output logic        a_vld,
   input  logic        b_req,
   input  logic [12:0] b_adr,
   input  logic [7:0]  b_wrt,
   input  logic        b_wen,
   output logic        b_gnt,
   output logic [7:0]  b_red,
   output logic        b_vld,
   output logic [12:0] tm_adr,
   output logic [7:0]  tm_wrt,
   output logic        tm_wen,
   input  logic [7:0]  tm_red
);

   typedef enum logic [1:0] {StIdle, StGnt, StWait, StRet} state_e;

   localparam logic [3:0] StarveLim = 4'(STARVE);
   localparam logic [1:0] WaitLast  = 2'(RD_LAT - 1);

   state_e      state_q;
   logic [3:0]  lose_q;
   logic [1:0]  wcnt_q;
   logic        win_b_q;
   logic        a_gnt_q, b_gnt_q, a_vld_q, b_vld_q, tm_wen_q;
   logic [7:0]  a_red_q, b_red_q, tm_wrt_q;
   logic [12:0] tm_adr_q;
   logic        any_req, pick_b;

   assign any_req = a_req | b_req;
   assign pick_b  = b_req & (~a_req | (lose_q >= StarveLim));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         lose_q   <= '0;
         wcnt_q   <= '0;
         win_b_q  <= 1'b0;
         a_gnt_q  <= 1'b0;
         b_gnt_q  <= 1'b0;
         a_vld_q  <= 1'b0;
         b_vld_q  <= 1'b0;
         a_red_q  <= '0;
         b_red_q  <= '0;
         tm_adr_q <= '0;
         tm_wrt_q <= '0;
         tm_wen_q <= 1'b0;
      end else begin
         a_gnt_q <= 1'b0;
         b_gnt_q <= 1'b0;
         a_vld_q <= 1'b0;
         b_vld_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (any_req) begin
                  win_b_q  <= pick_b;
                  a_gnt_q  <= ~pick_b;
                  b_gnt_q  <= pick_b;
                  tm_adr_q <= pick_b ? b_adr : a_adr;
                  tm_wrt_q <= pick_b ? b_wrt : a_wrt;
                  tm_wen_q <= pick_b ? b_wen : a_wen;
                  if (pick_b) begin
                     lose_q <= '0;
                  end else if (b_req && lose_q != 4'hF) begin
                     lose_q <= lose_q + 4'd1;
                  end
                  state_q <= StGnt;
               end
            end
            StGnt: begin
               // tm_wen_q still holds the latched direction of this access
               tm_wen_q <= 1'b0;
               wcnt_q   <= '0;
               state_q  <= tm_wen_q ? StIdle : StWait;
            end
            StWait: begin
               if (wcnt_q == WaitLast) begin
                  if (win_b_q) begin
                     b_red_q <= tm_red;
                     b_vld_q <= 1'b1;
                  end else begin
                     a_red_q <= tm_red;
                     a_vld_q <= 1'b1;
                  end
                  state_q <= StRet;
               end else begin
                  wcnt_q <= wcnt_q + 2'd1;
               end
            end
            StRet: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign a_gnt  = a_gnt_q;
   assign b_gnt  = b_gnt_q;
   assign a_vld  = a_vld_q;
   assign b_vld  = b_vld_q;
   assign a_red  = a_red_q;
   assign b_red  = b_red_q;
   assign tm_adr = tm_adr_q;
   assign tm_wrt = tm_wrt_q;
   assign tm_wen = tm_wen_q;

endmodule

// File: tb/tb_fpga_robots_game_tmarb.sv
// Bench for fpga_robots_game_tmarb: two instances (RD_LAT 1/STARVE 4, RD_LAT 3/STARVE 2)
// driven with shared stimulus and checked every cycle against a transaction-level model.
module tb_fpga_robots_game_tmarb;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, b_req, a_wen, b_wen;
   logic [12:0] a_adr, b_adr;
   logic [7:0]  a_wrt, b_wrt;

   logic        a_gnt_w[2], b_gnt_w[2], a_vld_w[2], b_vld_w[2], tm_wen_w[2];
   logic [7:0]  a_red_w[2], b_red_w[2], tm_wrt_w[2], tm_red_w[2];
   logic [12:0] tm_adr_w[2];

   int npass = 0;
   int ntot  = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   fpga_robots_game_tmarb #(.RD_LAT(1), .STARVE(4)) u_dut0 (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_adr(a_adr), .a_wrt(a_wrt), .a_wen(a_wen),
      .a_gnt(a_gnt_w[0]), .a_red(a_red_w[0]), .a_vld(a_vld_w[0]),
      .b_req(b_req), .b_adr(b_adr), .b_wrt(b_wrt), .b_wen(b_wen),
      .b_gnt(b_gnt_w[0]), .b_red(b_red_w[0]), .b_vld(b_vld_w[0]),
      .tm_adr(tm_adr_w[0]), .tm_wrt(tm_wrt_w[0]), .tm_wen(tm_wen_w[0]),
      .tm_red(tm_red_w[0])
   );

   fpga_robots_game_tmarb #(.RD_LAT(3), .STARVE(2)) u_dut1 (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_adr(a_adr), .a_wrt(a_wrt), .a_wen(a_wen),
      .a_gnt(a_gnt_w[1]), .a_red(a_red_w[1]), .a_vld(a_vld_w[1]),
      .b_req(b_req), .b_adr(b_adr), .b_wrt(b_wrt), .b_wen(b_wen),
      .b_gnt(b_gnt_w[1]), .b_red(b_red_w[1]), .b_vld(b_vld_w[1]),
      .tm_adr(tm_adr_w[1]), .tm_wrt(tm_wrt_w[1]), .tm_wen(tm_wen_w[1]),
      .tm_red(tm_red_w[1])
   );

   function automatic int lat_of(int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic int starve_of(int d);
      return (d == 0) ? 4 : 2;
   endfunction

   // Tile-map memory: data only valid exactly RD_LAT cycles after the grant cycle
   bit [7:0] rmem[2][8192];
   int       due[2] = '{-1, -1};
   bit [7:0] rdat[2];
   int       rcyc = 0;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if ((a_gnt_w[d] || b_gnt_w[d]) && tm_wen_w[d]) begin
            rmem[d][tm_adr_w[d]] = tm_wrt_w[d];
         end else if (a_gnt_w[d] || b_gnt_w[d]) begin
            due[d]  = rcyc + lat_of(d);
            rdat[d] = rmem[d][tm_adr_w[d]];
         end
         tm_red_w[d] = (rcyc == due[d]) ? rdat[d] : 8'($urandom);
      end
      rcyc++;
   end

   // Transaction-level model
   bit [7:0]  mmem[2][8192];
   int        busy[2], rd_cnt[2], lose[2];
   bit        rd_pend[2], rd_b[2];
   bit [7:0]  rd_data[2];
   bit        e_agnt[2], e_bgnt[2], e_avld[2], e_bvld[2], e_wen[2];
   bit [7:0]  e_ared[2], e_bred[2], e_wrt[2];
   bit [12:0] e_adr[2];

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         busy[d] = 0; rd_cnt[d] = 0; lose[d] = 0; rd_pend[d] = 0; rd_b[d] = 0;
         e_agnt[d] = 0; e_bgnt[d] = 0; e_avld[d] = 0; e_bvld[d] = 0; e_wen[d] = 0;
         e_ared[d] = 0; e_bred[d] = 0; e_wrt[d] = 0; e_adr[d] = 0;
      end
   endtask

   // Predict outputs after the coming edge from the inputs now applied
   task automatic model_step();
      bit        wb, wen;
      bit [12:0] adr;
      bit [7:0]  wrt;
      for (int d = 0; d < 2; d++) begin
         e_agnt[d] = 0; e_bgnt[d] = 0; e_avld[d] = 0; e_bvld[d] = 0; e_wen[d] = 0;
         if (rd_pend[d]) begin
            rd_cnt[d]--;
            if (rd_cnt[d] == 0) begin
               rd_pend[d] = 0;
               if (rd_b[d]) begin e_bvld[d] = 1; e_bred[d] = rd_data[d]; end
               else         begin e_avld[d] = 1; e_ared[d] = rd_data[d]; end
            end
         end
         if (busy[d] > 0) begin
            busy[d]--;
         end else if (a_req || b_req) begin
            wb  = b_req && (!a_req || lose[d] >= starve_of(d));
            if (wb) lose[d] = 0;
            else if (b_req && lose[d] < 15) lose[d]++;
            adr = wb ? b_adr : a_adr;
            wrt = wb ? b_wrt : a_wrt;
            wen = wb ? b_wen : a_wen;
            e_adr[d] = adr; e_wrt[d] = wrt; e_wen[d] = wen;
            e_agnt[d] = !wb; e_bgnt[d] = wb;
            if (wen) begin
               mmem[d][adr] = wrt;
               busy[d] = 1;
            end else begin
               rd_pend[d] = 1; rd_b[d] = wb; rd_cnt[d] = lat_of(d) + 1;
               rd_data[d] = mmem[d][adr];
               busy[d] = lat_of(d) + 2;
            end
         end
      end
   endtask

   function automatic logic [63:0] outv(int d);
      return {22'h0, a_gnt_w[d], b_gnt_w[d], a_vld_w[d], b_vld_w[d], a_red_w[d], b_red_w[d],
              tm_adr_w[d], tm_wrt_w[d], tm_wen_w[d]};
   endfunction

   function automatic logic [63:0] expv(int d);
      return {22'h0, e_agnt[d], e_bgnt[d], e_avld[d], e_bvld[d], e_ared[d], e_bred[d],
              e_adr[d], e_wrt[d], e_wen[d]};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) chk($sformatf("cycle%0d_dut%0d", cyc, d), outv(d), expv(d));
      cyc++;
   endtask

   task automatic set_a(bit req, bit wen, bit [12:0] adr, bit [7:0] wrt);
      a_req = req; a_wen = wen; a_adr = adr; a_wrt = wrt;
   endtask

   task automatic set_b(bit req, bit wen, bit [12:0] adr, bit [7:0] wrt);
      b_req = req; b_wen = wen; b_adr = adr; b_wrt = wrt;
   endtask

   initial begin
      logic [9:0] seq0, seq1;
      logic [5:0] pat, pv, pg;
      int         gn0, gn1;

      rst = 1'b0;
      set_a(0, 0, 13'h0, 8'h0);
      set_b(0, 0, 13'h0, 8'h0);
      model_reset();
      repeat (3) @(posedge clk);
      #1 chk("reset_hold_dut0", outv(0), 64'h0);
      chk("reset_hold_dut1", outv(1), 64'h0);
      @(negedge clk) rst = 1'b1;
      tick();
      chk("reset_state_dut0", outv(0), 64'h0);

      // A write
      set_a(1, 1, 13'h0123, 8'h5A);
      tick();
      chk("a_write_gnt", {a_gnt_w[0], b_gnt_w[0], tm_wen_w[0], tm_adr_w[0], tm_wrt_w[0]},
          {1'b1, 1'b0, 1'b1, 13'h0123, 8'h5A});
      set_a(0, 0, 13'h0, 8'h0);
      tick();
      chk("a_write_idle", {a_gnt_w[0], tm_wen_w[0]}, 2'b00);

      // B write 0xC3 to 0x1FFF, then read it back
      set_b(1, 1, 13'h1FFF, 8'hC3);
      tick();
      set_b(0, 0, 13'h0, 8'h0);
      tick();
      set_b(1, 0, 13'h1FFF, 8'h00);
      tick();
      chk("b_read_gnt", b_gnt_w[0], 1'b1);
      set_b(0, 0, 13'h0, 8'h0);
      tick();
      chk("b_read_n1_novld", b_vld_w[0], 1'b0);
      tick();
      chk("b_read_n2", {b_vld_w[0], b_red_w[0], a_vld_w[0]}, {1'b1, 8'hC3, 1'b0});
      repeat (6) tick();

      // Continuous contention: starvation guard
      set_a(1, 1, 13'h0040, 8'h11);
      set_b(1, 1, 13'h0041, 8'h22);
      seq0 = '0; seq1 = '0; gn0 = 0; gn1 = 0;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (a_gnt_w[0] || b_gnt_w[0]) begin seq0 = {seq0[8:0], b_gnt_w[0]}; gn0++; end
         if (a_gnt_w[1] || b_gnt_w[1]) begin seq1 = {seq1[8:0], b_gnt_w[1]}; gn1++; end
      end
      chk("starve4_order", seq0, 10'b0000100001);
      chk("starve4_count", gn0, 10);
      chk("starve2_order", seq1, 10'b0010010010);
      set_a(0, 0, 13'h0, 8'h0);
      set_b(0, 0, 13'h0, 8'h0);
      repeat (2) tick();

      // A held high over three writes
      set_a(1, 1, 13'h0200, 8'h33);
      pat = '0;
      for (int t = 0; t < 6; t++) begin
         tick();
         pat = {pat[4:0], a_gnt_w[0]};
      end
      chk("a_held_gnt_pattern", pat, 6'b101010);
      set_a(0, 0, 13'h0, 8'h0);
      repeat (2) tick();

      // RD_LAT=3 read by A with B waiting
      set_a(1, 0, 13'h0123, 8'h00);
      set_b(1, 1, 13'h0300, 8'h44);
      tick();
      chk("lat3_a_gnt", a_gnt_w[1], 1'b1);
      set_a(0, 0, 13'h0, 8'h0);
      pv = '0; pg = '0;
      for (int t = 1; t <= 6; t++) begin
         tick();
         pv = {pv[4:0], a_vld_w[1]};
         pg = {pg[4:0], b_gnt_w[1]};
         if (t == 4) chk("lat3_a_red", a_red_w[1], 8'h5A);
      end
      chk("lat3_a_vld_cycle", pv, 6'b000100);
      chk("lat3_b_gnt_cycle", pg, 6'b000001);
      set_b(0, 0, 13'h0, 8'h0);
      repeat (4) tick();

      // Reset asserted while in WAIT
      set_a(1, 0, 13'h0123, 8'h00);
      tick();
      set_a(0, 0, 13'h0, 8'h0);
      tick();
      #2 rst = 1'b0;
      #1 chk("reset_mid_dut1", outv(1), 64'h0);
      chk("reset_mid_dut0", outv(0), 64'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 chk("reset_no_vld", {a_vld_w[1], b_vld_w[1], a_vld_w[0], b_vld_w[0]}, 4'b0000);
      @(negedge clk) rst = 1'b1;
      set_a(1, 1, 13'h0ABC, 8'h77);
      tick();
      chk("post_reset_write", {a_gnt_w[1], tm_wen_w[1], tm_adr_w[1], tm_wrt_w[1]},
          {1'b1, 1'b1, 13'h0ABC, 8'h77});
      set_a(0, 0, 13'h0, 8'h0);
      repeat (2) tick();

      // Randomized traffic on a small address window so reads see earlier writes
      for (int t = 0; t < 1500; t++) begin
         set_a($urandom_range(0, 99) < 55, $urandom_range(0, 1),
               ($urandom_range(0, 19) == 0) ? 13'($urandom) : 13'($urandom_range(0, 7)),
               8'($urandom));
         set_b($urandom_range(0, 99) < 45, $urandom_range(0, 1),
               ($urandom_range(0, 19) == 0) ? 13'($urandom) : 13'($urandom_range(0, 7)),
               8'($urandom));
         tick();
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/fpga_robots_game_tmarb.md
FPGA_ROBOTS_GAME_TMARB -- requirements
Module: fpga_robots_game_tmarb

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, meaning tile map read latency in clk cycles from tm_adr valid to tm_red valid (legal 1..3).
REQ-002 SHALL have parameter STARVE, default 4, meaning the maximum consecutive contested grants to requester A while B waits (legal 1..15).
REQ-003 SHALL have port clk  input  1  system clock; sole clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low (low = reset).
REQ-005 SHALL have ports a_req/b_req  input  1  access request from A (game play) / B (host debug).
REQ-006 SHALL have ports a_adr/b_adr  input  13  tile map address.
REQ-007 SHALL have ports a_wrt/b_wrt  input  8  write data.
REQ-008 SHALL have ports a_wen/b_wen  input  1  1 = write, 0 = read.
REQ-009 SHALL have ports a_gnt/b_gnt  output  1  one-cycle grant; the access is transferred when req and gnt are both high.
REQ-010 SHALL have ports a_red/b_red  output  8  read data return.
REQ-011 SHALL have ports a_vld/b_vld  output  1  one-cycle read data valid.
REQ-012 SHALL have ports tm_adr  output  13, tm_wrt  output  8, tm_wen  output  1, tm_red  input  8  shared tile map memory port.

Function
REQ-013 SHALL implement FSM states IDLE, GNT, WAIT, RET; all outputs SHALL be registered.
REQ-014 IDLE: if any req is high, SHALL select a winner, latch its adr/wrt/wen, and go to GNT; otherwise SHALL stay in IDLE.
REQ-015 Winner selection: A only or B only -> that requester; both -> A, unless lose_ctr >= STARVE, in which case B.
REQ-016 lose_ctr: 4-bit; SHALL increment (saturating at 15) when A wins with B also requesting, clear to 0 when B wins, and hold otherwise.
REQ-017 GNT, lasting 1 cycle: SHALL drive tm_adr and tm_wrt with the latched values, tm_wen equal to the latched wen, and the winner's gnt equal to 1.
REQ-018 From GNT, a write SHALL go to IDLE and a read SHALL go to WAIT.
REQ-019 WAIT SHALL last exactly RD_LAT cycles, counted by a 2-bit counter; at the edge ending the last WAIT cycle, tm_red SHALL be captured into the winner's red register.
REQ-020 RET, lasting 1 cycle: SHALL assert the winner's vld = 1, then go to IDLE.
REQ-021 Read latency SHALL be: gnt in cycle N; vld and red in cycle N+RD_LAT+1.
REQ-022 Write occupancy SHALL be 2 cycles per access (IDLE, GNT); read occupancy SHALL be RD_LAT+3 cycles.
REQ-023 req, adr, wrt and wen SHALL be sampled only in IDLE; req held high during GNT/WAIT/RET SHALL be ignored.
REQ-024 req still high in the IDLE cycle after gnt SHALL be treated as a new request (back-to-back allowed).
REQ-025 tm_wen SHALL be 1 only in GNT for a write; it SHALL be 0 in all other states.
REQ-026 tm_adr and tm_wrt SHALL hold their last values outside GNT.
REQ-027 red registers SHALL hold their values until the next read return to the same requester.
REQ-028 Only one of a_gnt/b_gnt SHALL be high in any cycle, and likewise only one of a_vld/b_vld.
REQ-029 Request withdrawn before IDLE samples it: no grant SHALL be issued and no state SHALL change.

Reset
REQ-030 While rst is low, state SHALL be IDLE, and lose_ctr, the WAIT counter, tm_adr, tm_wrt, tm_wen, a/b_gnt, a/b_vld and a/b_red SHALL all be 0, asynchronously.
REQ-031 Reset asserted mid-access (GNT/WAIT/RET) SHALL abort the access with no vld issued.
REQ-032 After rst deassertion, the first request SHALL be sampled no earlier than the first clk edge following deassertion.

Verification
REQ-033 A write a_adr=0x0123, a_wrt=0x5A -> a_gnt=1 and tm_wen=1, tm_adr=0x0123, tm_wrt=0x5A in the same cycle; the next cycle is IDLE.
REQ-034 B read b_adr=0x1FFF, memory returns 0xC3, RD_LAT=1 -> b_gnt in cycle N; b_vld=1 with b_red=0xC3 in cycle N+2; a_vld stays 0.
REQ-035 A and B both request continuously with STARVE=4 -> grant order A,A,A,A,B,A,A,A,A,B; lose_ctr returns to 0 after each B grant.
REQ-036 a_req held high across 3 writes -> three a_gnt pulses, each 2 cycles apart, with no duplicate grant.
REQ-037 rst driven low during WAIT -> all outputs go to 0 immediately, no vld is issued, and an A write issued after release completes normally.
REQ-038 RD_LAT=3, A read -> exactly 3 WAIT cycles; a_vld in cycle N+4; a simultaneous B request is granted in cycle N+6.
